// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter: arbitrates NREQ byte producers onto one tx line
// and sequences start / DATA_W data bits (LSB first) / stop from an internal bit timer.
module uart_tx_sched #(
    parameter int NREQ         = 2,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 10,
    localparam int ID_W        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id
);
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [ID_W-1:0]       gid_q, gid_d;
    logic [ID_W-1:0]       rr_q, rr_d;

    logic [NREQ-1:0][DATA_W-1:0] data_lane;
    logic [ID_W-1:0]       win;
    logic                  win_found;
    logic [ID_W:0]         cand;
    logic [ID_W:0]         rr_next;
    logic                  bit_end;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign data_lane[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Circular search for the first valid requester at or after the RR pointer.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ))
                cand = cand - (ID_W+1)'(NREQ);
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win       = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        rr_next = {1'b0, win} + (ID_W+1)'(1);
        if (rr_next >= (ID_W+1)'(NREQ))
            rr_next = '0;
    end

    // Ready is held low during reset even though the FSM already sits in IDLE.
    always_comb begin
        req_ready = '0;
        if (rst && state_q == IDLE && win_found)
            req_ready[win] = 1'b1;
    end

    assign bit_end = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        if (state_q != IDLE)
            tmr_d = bit_end ? '0 : tmr_q + TMR_W'(1);
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (win_found) begin
                    shift_d = data_lane[win];
                    gid_d   = win;
                    rr_d    = rr_next[ID_W-1:0];
                    tmr_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: scoreboard of expected grants and frame bytes checked by
// accept and serial-line monitors, with one task per scenario.
module tb_uart_tx_sched;
    localparam int NREQ   = 2;
    localparam int DATA_W = 8;
    localparam int CPB    = 10;
    localparam int ID_W   = $clog2(NREQ);
    localparam int FRAME  = (DATA_W + 2) * CPB;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   tx;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_data_q[$];
    int                exp_id_q[$];

    logic mon_in = 1'b0;

    uart_tx_sched #(.NREQ(NREQ), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Serial-line monitor: every cycle of a frame must match the expected bit pattern.
    initial begin
        int cnt;
        int bad;
        bit have;
        logic [DATA_W+1:0] pat;
        cnt = 0; bad = 0; have = 0; pat = '1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_in = 1'b0;
            end else begin
                if (!mon_in && tx === 1'b0) begin
                    mon_in = 1'b1; cnt = 0; bad = 0;
                    if (exp_data_q.size() == 0) begin
                        have = 0; pat = '1;
                    end else begin
                        have = 1; pat = {1'b1, exp_data_q.pop_front(), 1'b0};
                    end
                end
                if (mon_in) begin
                    if (cnt < FRAME) begin
                        if (tx !== pat[cnt / CPB] || busy !== 1'b1) bad++;
                        cnt++;
                    end else begin
                        if (tx !== 1'b1 || busy !== 1'b0) bad++;
                        checks++;
                        if (!have || bad != 0) begin
                            errors++;
                            $display("FAIL frame: byte %02h had %0d bad cycles (expected entry %0d), required 0 bad cycles and an expected entry",
                                     pat[DATA_W:1], bad, have);
                        end
                        mon_in = 1'b0;
                    end
                end
            end
        end
    end

    // Accept monitor: each ready pulse must be the scoreboarded one-hot winner.
    initial begin
        bit pend;
        int gexp;
        int id;
        logic [NREQ-1:0] oh;
        pend = 0; gexp = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                checks++;
                if (grant_id !== ID_W'(gexp)) begin
                    errors++;
                    $display("FAIL grant_id: got %0d required %0d", grant_id, gexp);
                end
                pend = 0;
            end
            if (rst && req_ready !== '0) begin
                checks++;
                if (exp_id_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept_unexpected: ready %b required none", req_ready);
                end else begin
                    id = exp_id_q.pop_front();
                    oh = '0; oh[id] = 1'b1;
                    if (req_ready !== oh || (req_ready & ~req_valid) != '0) begin
                        errors++;
                        $display("FAIL accept_onehot: ready %b valid %b required ready %b", req_ready, req_valid, oh);
                    end
                    gexp = id; pend = 1;
                end
            end
        end
    end

    task automatic drive_step();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while ((exp_data_q.size() != 0 || exp_id_q.size() != 0 || mon_in || busy) && n < 3000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        ok = (n < 3000);
    endtask

    task automatic do_reset();
        req_valid = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push(input int id, input logic [DATA_W-1:0] d);
        exp_id_q.push_back(id);
        exp_data_q.push_back(d);
    endtask

    task automatic send_one(input int id, input logic [DATA_W-1:0] d, output bit ok);
        int n;
        push(id, d);
        drive_step();
        req_data[id*DATA_W +: DATA_W] = d;
        req_valid[id] = 1'b1;
        n = 0; ok = 0;
        while (!ok && n < 300) begin
            @(negedge clk); n++;
            if (req_ready[id]) ok = 1;
        end
        drive_step();
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b01;
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0 || grant_id !== '0) begin
            errors++;
            $display("FAIL reset_state: tx %b busy %b ready %b gid %0d required 1 0 00 0", tx, busy, req_ready, grant_id);
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single_frame();
        int rdy_cnt, busy_cnt;
        bit ok;
        push(0, 8'hA5);
        drive_step();
        req_data[7:0] = 8'hA5;
        req_valid = 2'b01;
        rdy_cnt = 0; busy_cnt = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (req_ready[0] === 1'b1) begin
                rdy_cnt++;
                drive_step();
                req_valid = '0;
            end
        end
        checks++;
        if (rdy_cnt != 1) begin
            errors++; $display("FAIL single_ready_cycles: got %0d required 1", rdy_cnt);
        end
        checks++;
        if (busy_cnt != FRAME) begin
            errors++; $display("FAIL single_busy_cycles: got %0d required %0d", busy_cnt, FRAME);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got busy %b required idle", busy); end
    endtask

    task automatic test_rr_alternate();
        int t[4];
        int na, n;
        bit ok;
        do_reset();
        push(0, 8'h11); push(1, 8'h22); push(0, 8'h11); push(1, 8'h22);
        req_data = {8'h22, 8'h11};
        req_valid = 2'b11;
        na = 0; n = 0;
        while (na < 4 && n < 600) begin
            @(negedge clk); n++;
            if (req_ready !== '0) begin
                t[na] = n; na++;
                if (na == 4) begin drive_step(); req_valid = '0; end
            end
        end
        req_valid = '0;
        checks++;
        if (na != 4) begin errors++; $display("FAIL rr_accepts: got %0d required 4", na); end
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < na) begin
                checks++;
                if (t[i+1] - t[i] != FRAME + 1) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d required %0d", i, t[i+1] - t[i], FRAME + 1);
                end
            end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: got busy %b required idle", busy); end
    endtask

    task automatic test_lone_requester();
        int na, r0, n;
        bit ok;
        push(1, 8'h3C); push(1, 8'h3C); push(1, 8'h3C);
        drive_step();
        req_data[15:8] = 8'h3C;
        req_valid = 2'b10;
        na = 0; r0 = 0; n = 0;
        while (na < 3 && n < 600) begin
            @(negedge clk); n++;
            if (req_ready[0] === 1'b1) r0++;
            if (req_ready[1] === 1'b1) begin
                na++;
                if (na == 3) begin drive_step(); req_valid = '0; end
            end
        end
        req_valid = '0;
        checks++;
        if (na != 3) begin errors++; $display("FAIL lone_accepts: got %0d required 3", na); end
        checks++;
        if (r0 != 0) begin errors++; $display("FAIL lone_ready0: got %0d cycles required 0", r0); end
        wait_done(ok);
        checks++;
        if (!ok || grant_id !== 1'b1) begin
            errors++; $display("FAIL lone_final: gid %0d ok %0d required gid 1 ok 1", grant_id, ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        send_one(0, 8'h00, ok);
        repeat (39) @(posedge clk);
        #3;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_pre: tx %b required 0", tx); end
        req_valid = 2'b01;
        req_data[7:0] = 8'hC3;
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL midframe_reset: tx %b busy %b ready %b required 1 0 00", tx, busy, req_ready);
        end
        repeat (2) @(posedge clk);
        push(0, 8'hC3);
        #1 rst = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[0] === 1'b1) ok = 1;
        end
        drive_step();
        req_valid = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL midframe_regrant: got none required ready[0]"); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midframe_timeout: got busy %b required idle", busy); end
    endtask

    task automatic test_data_stability();
        int seen;
        bit ok;
        send_one(0, 8'h5A, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stab_accept: got none required ready[0]"); end
        repeat (30) drive_step();
        req_data = {8'h77, 8'hFF};
        req_valid[1] = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready !== '0) seen++;
        end
        drive_step();
        req_valid = '0;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL stab_ready_in_data: got %0d cycles required 0", seen); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stab_timeout: got busy %b required idle", busy); end
    endtask

    task automatic test_drop_before_grant();
        int bad;
        bit ok;
        send_one(0, 8'h96, ok);
        repeat (20) drive_step();
        req_valid[1] = 1'b1;
        repeat (10) drive_step();
        req_valid[1] = 1'b0;
        drive_step();
        req_valid[1] = 1'b1;
        repeat (10) drive_step();
        req_valid[1] = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_timeout: got busy %b required idle", busy); end
        bad = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (req_ready !== '0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL drop_idle_quiet: got %0d bad cycles required 0", bad); end
        checks++;
        if (grant_id !== 1'b0) begin errors++; $display("FAIL drop_gid: got %0d required 0", grant_id); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_rr_alternate();
        test_lone_requester();
        test_reset_mid_frame();
        test_data_stability();
        test_drop_before_grant();
        checks++;
        if (exp_id_q.size() != 0 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: ids %0d bytes %0d left required 0 0", exp_id_q.size(), exp_data_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
